uart_word_loader: RTL and testbench

Controller that sits between the byte-level UART core and the design's 32-bit instruction memory. It consumes received ASCII hex characters, assembles 8 digits into one 32-bit word, and writes the word to memory at an auto-incrementing address. For each completed line it sends a one-byte status code back through the UART transmitter. It owns the UART `rdy_clr` and `wr_en` handshakes, so no other logic drives them.

---
 rtl/uart_word_loader_if.sv | 27 ++
 rtl/uart_word_loader.sv | 207 ++++++++++++++++++++
 tb/tb_uart_word_loader.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_loader_if.sv
// Handshake bundle between the hex-line loader, the byte UART core and the instruction memory.
// master is the loader side; slave is the UART/memory side.
interface uart_word_loader_if #(
    parameter int unsigned ADDR_W = 4
) ();
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              rx_rdy_clr;
    logic              tx_busy;
    logic [7:0]        tx_din;
    logic              tx_wr_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              full;
    logic              err;

    modport master (
        input  rx_rdy, rx_data, tx_busy,
        output rx_rdy_clr, tx_din, tx_wr_en, mem_we, mem_addr, mem_wdata, full, err
    );

    modport slave (
        output rx_rdy, rx_data, tx_busy,
        input  rx_rdy_clr, tx_din, tx_wr_en, mem_we, mem_addr, mem_wdata, full, err
    );
endinterface

// File: rtl/uart_word_loader.sv
// Assembles ASCII hex lines from the UART into 32-bit words written at an auto-incrementing
// address, answering each line with K/E/F. Define UART_LOADER_ECHO_EN to echo accepted bytes.
module uart_word_loader #(
    parameter int unsigned ADDR_W = 4
) (
    input logic                clk,
    input logic                rst_n,
    uart_word_loader_if.master ldr_io
);

`ifdef UART_LOADER_ECHO_EN
    localparam bit EchoEn = 1'b1;
`else
    localparam bit EchoEn = 1'b0;
`endif

    localparam logic [7:0] RespK = 8'h4B;
    localparam logic [7:0] RespE = 8'h45;
    localparam logic [7:0] RespF = 8'h46;

    typedef enum logic [2:0] {StIdle, StClr, StGap, StResp, StHold} state_e;

    state_e            state_q, state_d;
    logic              clr_q, clr_d;
    logic              we_q, we_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        din_q, din_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              stat_pend_q, stat_pend_d;
    logic [7:0]        stat_q, stat_d;
    logic              echo_pend_q, echo_pend_d;
    logic [7:0]        echo_q, echo_d;

    logic [7:0] rx_b;
    logic       is_hex, is_term, is_rew, send;
    logic [3:0] nib;

    assign rx_b = ldr_io.rx_data;

    always_comb begin
        is_hex  = 1'b0;
        nib     = 4'h0;
        is_term = (rx_b == 8'h0D) || (rx_b == 8'h0A);
        is_rew  = (rx_b == 8'h52);
        if (rx_b >= 8'h30 && rx_b <= 8'h39) begin
            is_hex = 1'b1;
            nib    = rx_b[3:0];
        end else if ((rx_b >= 8'h41 && rx_b <= 8'h46) || (rx_b >= 8'h61 && rx_b <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = rx_b[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_d       = 1'b0;
        we_d        = 1'b0;
        wr_en_d     = 1'b0;
        din_d       = din_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        full_d      = full_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        stat_pend_d = stat_pend_q;
        stat_d      = stat_q;
        echo_pend_d = echo_pend_q;
        echo_d      = echo_q;
        send        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ldr_io.rx_rdy) begin
                    // Decode here so rx_rdy_clr and mem_we are both registered into the CLR cycle.
                    state_d     = StClr;
                    clr_d       = 1'b1;
                    echo_pend_d = EchoEn;
                    echo_d      = rx_b;
                    if (is_hex) begin
                        if (cnt_q < 4'd8) begin
                            wdata_d = {wdata_q[27:0], nib};
                            cnt_d   = cnt_q + 4'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (is_term) begin
                        cnt_d = 4'd0;
                        ovf_d = 1'b0;
                        if (ovf_q || (cnt_q != 4'd0 && cnt_q != 4'd8)) begin
                            stat_pend_d = 1'b1;
                            stat_d      = RespE;
                            err_d       = 1'b1;
                        end else if (cnt_q == 4'd8) begin
                            stat_pend_d = 1'b1;
                            if (full_q) begin
                                stat_d = RespF;
                            end else begin
                                stat_d = RespK;
                                we_d   = 1'b1;
                            end
                        end
                    end else if (is_rew) begin
                        addr_d      = '0;
                        full_d      = 1'b0;
                        err_d       = 1'b0;
                        cnt_d       = 4'd0;
                        ovf_d       = 1'b0;
                        stat_pend_d = 1'b1;
                        stat_d      = RespK;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            StClr: begin
                state_d = StGap;
                if (we_q) begin
                    addr_d = addr_q + 1'b1;
                    if (&addr_q) full_d = 1'b1;
                end
            end
            StGap: begin
                if (echo_pend_q || stat_pend_q) begin
                    state_d = StResp;
                    send    = !ldr_io.tx_busy;
                end else begin
                    state_d = StIdle;
                end
            end
            StResp: begin
                if (wr_en_q) begin
                    state_d = StHold;
                end else begin
                    send = !ldr_io.tx_busy;
                end
            end
            StHold: begin
                state_d = (echo_pend_q || stat_pend_q) ? StResp : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Echo always goes out ahead of the status byte for the same character.
        if (send) begin
            wr_en_d = 1'b1;
            if (echo_pend_q) begin
                din_d       = echo_q;
                echo_pend_d = 1'b0;
            end else begin
                din_d       = stat_q;
                stat_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            clr_q       <= 1'b0;
            we_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            din_q       <= 8'h00;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 4'd0;
            ovf_q       <= 1'b0;
            stat_pend_q <= 1'b0;
            stat_q      <= 8'h00;
            echo_pend_q <= 1'b0;
            echo_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            we_q        <= we_d;
            wr_en_q     <= wr_en_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            full_q      <= full_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            stat_pend_q <= stat_pend_d;
            stat_q      <= stat_d;
            echo_pend_q <= echo_pend_d;
            echo_q      <= echo_d;
        end
    end

    assign ldr_io.rx_rdy_clr = clr_q;
    assign ldr_io.tx_din     = din_q;
    assign ldr_io.tx_wr_en   = wr_en_q;
    assign ldr_io.mem_we     = we_q;
    assign ldr_io.mem_addr   = addr_q;
    assign ldr_io.mem_wdata  = wdata_q;
    assign ldr_io.full       = full_q;
    assign ldr_io.err        = err_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: line-level reference model, monitored write/transmit streams,
// directed scenarios plus a randomized character stream.
module tb_uart_word_loader;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned Depth  = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_word_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_word_loader #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ldr_io (bus)
    );

    // Transmitter emulation: busy for a random few cycles after each strobe.
    logic force_busy = 1'b0;
    int   busy_cnt = 0;
    assign bus.tx_busy = force_busy || (busy_cnt != 0);
    always @(posedge clk) begin
        if (bus.tx_wr_en) busy_cnt <= $urandom_range(1, 6);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collects the write and transmit streams and protocol violations.
    logic [63:0] obs_wr[$];
    logic [7:0]  obs_tx[$];
    int viol = 0, n_clr = 0, clr_cyc = 0, tx_lat = -1, we_lat = -1, addr_after_we = -1;
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (prev_we) addr_after_we = int'(bus.mem_addr);
        prev_we = bus.mem_we;
        if (bus.rx_rdy_clr) begin
            clr_cyc = cyc;
            tx_lat  = -1;
            n_clr++;
        end
        if (bus.mem_we) begin
            obs_wr.push_back({32'(bus.mem_addr), bus.mem_wdata});
            we_lat = cyc - clr_cyc;
        end
        if (bus.tx_wr_en) begin
            obs_tx.push_back(bus.tx_din);
            if (tx_lat < 0) tx_lat = cyc - clr_cyc;
            if (bus.rx_rdy_clr || bus.tx_busy) viol++;
        end
    end

    // Reference model of the line protocol.
    logic [63:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          m_cnt, m_addr;
    bit          m_ovf, m_full, m_err;
    logic [31:0] m_word;
    int n_checks = 0, n_pass = 0;

    task automatic mdl_reset();
        m_cnt = 0; m_addr = 0; m_ovf = 0; m_full = 0; m_err = 0; m_word = 32'h0;
    endtask

    task automatic mdl_byte(input logic [7:0] b);
        int v;
        v = -1;
        if (b >= 8'h30 && b <= 8'h39) v = int'(b) - 48;
        else if (b >= 8'h41 && b <= 8'h46) v = int'(b) - 55;
        else if (b >= 8'h61 && b <= 8'h66) v = int'(b) - 87;
`ifdef UART_LOADER_ECHO_EN
        exp_tx.push_back(b);
`endif
        if (v >= 0) begin
            if (m_cnt < 8) begin
                m_word = (m_word << 4) | 32'(v);
                m_cnt++;
            end else m_ovf = 1;
        end else if (b == 8'h0D || b == 8'h0A) begin
            if (m_cnt != 0 || m_ovf) begin
                if (m_ovf || m_cnt < 8) begin
                    exp_tx.push_back(8'h45);
                    m_err = 1;
                end else if (m_full) exp_tx.push_back(8'h46);
                else begin
                    exp_wr.push_back({32'(m_addr), m_word});
                    exp_tx.push_back(8'h4B);
                    if (m_addr == Depth - 1) begin
                        m_addr = 0;
                        m_full = 1;
                    end else m_addr++;
                end
            end
            m_cnt = 0; m_ovf = 0;
        end else if (b == 8'h52) begin
            mdl_reset();
            m_word = m_word;
            exp_tx.push_back(8'h4B);
        end else m_ovf = 1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        mdl_byte(b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.rx_rdy_clr && t < 300);
        if (!bus.rx_rdy_clr) begin
            n_checks++;
            $display("FAIL rx_accept: byte %h not consumed within %0d cycles", b, t);
        end
        bus.rx_rdy = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain();
        repeat (60) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rx_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus.mem_we, bus.rx_rdy_clr, bus.tx_wr_en} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000",
                     {bus.mem_we, bus.rx_rdy_clr, bus.tx_wr_en});
        else n_pass++;
        n_checks++;
        if ({bus.full, bus.err, 32'(bus.mem_addr)} !== 34'h0)
            $display("FAIL reset_flags: full=%b err=%b addr=%0d want 0", bus.full, bus.err,
                     bus.mem_addr);
        else n_pass++;
        n_checks++;
        if ({bus.mem_wdata, bus.tx_din} !== 40'h0)
            $display("FAIL reset_data: wdata=%h din=%h want 0", bus.mem_wdata, bus.tx_din);
        else n_pass++;
    endtask

    task automatic test_deadbeef();
        send_str("DEADBEEF");
        drain();
        send_byte(8'h0D);
        drain();
        n_checks++;
        if (obs_wr.size() !== 1 || exp_wr.size() !== 1)
            $display("FAIL dbf_writes: got %0d want 1", obs_wr.size());
        else n_pass++;
        n_checks++;
        if (obs_wr.size() < 1 || obs_wr[0] !== {32'd0, 32'hDEADBEEF})
            $display("FAIL dbf_word: got %h want %h", obs_wr.size() ? obs_wr[0] : 64'h0,
                     {32'd0, 32'hDEADBEEF});
        else n_pass++;
        n_checks++;
        if (obs_tx.size() < 1 || obs_tx[obs_tx.size()-1] !== 8'h4B)
            $display("FAIL dbf_resp: got %h want 4b", obs_tx.size() ? obs_tx[obs_tx.size()-1] : 8'h0);
        else n_pass++;
        n_checks++;
        if (int'(bus.mem_addr) !== 1) $display("FAIL dbf_addr: got %0d want 1", bus.mem_addr);
        else n_pass++;
        n_checks++;
        if (we_lat !== 0 || addr_after_we !== 1)
            $display("FAIL dbf_we_timing: we_lat=%0d addr_next=%0d want 0/1", we_lat, addr_after_we);
        else n_pass++;
        n_checks++;
        if (tx_lat !== 2) $display("FAIL dbf_tx_latency: got %0d want 2", tx_lat);
        else n_pass++;
    endtask

    task automatic test_error_rewind();
        int tx0, wr0;
        tx0 = obs_tx.size();
        wr0 = obs_wr.size();
        send_str("12");
        send_byte(8'h0D);
        send_byte(8'h0A);
        drain();
        n_checks++;
        if (bus.err !== 1'b1 || obs_wr.size() !== wr0)
            $display("FAIL err_set: err=%b writes=%0d want 1/%0d", bus.err, obs_wr.size(), wr0);
        else n_pass++;
        send_byte(8'h52);
        drain();
        n_checks++;
        if (bus.err !== 1'b0 || int'(bus.mem_addr) !== 0)
            $display("FAIL rewind: err=%b addr=%0d want 0/0", bus.err, bus.mem_addr);
        else n_pass++;
        n_checks++;
        if (obs_tx.size() !== exp_tx.size())
            $display("FAIL er_tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        for (int i = tx0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i])
                $display("FAIL er_tx[%0d]: got %h want %h", i, obs_tx[i], exp_tx[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full();
        int tx0, wr0;
        logic [7:0] d;
        tx0 = obs_tx.size();
        wr0 = obs_wr.size();
        for (int n = 0; n < 5; n++) begin
            d = 8'h30 + 8'(n);
            send_str("0000000");
            send_byte(d);
            send_byte(8'h0D);
            if (n == 3) begin
                drain();
                n_checks++;
                if (bus.full !== 1'b1 || int'(bus.mem_addr) !== 0)
                    $display("FAIL full_set: full=%b addr=%0d want 1/0", bus.full, bus.mem_addr);
                else n_pass++;
            end
        end
        drain();
        n_checks++;
        if (obs_wr.size() !== exp_wr.size() || exp_wr.size() - wr0 !== 4)
            $display("FAIL full_writes: got %0d want %0d", obs_wr.size() - wr0, 4);
        else n_pass++;
        for (int i = wr0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== exp_wr[i])
                $display("FAIL full_wr[%0d]: got %h want %h", i, obs_wr[i], exp_wr[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_tx.size() !== exp_tx.size() || obs_tx.size() == 0 ||
            obs_tx[obs_tx.size()-1] !== 8'h46)
            $display("FAIL full_resp: count=%0d want %0d, last=%h want 46", obs_tx.size(),
                     exp_tx.size(), obs_tx.size() ? obs_tx[obs_tx.size()-1] : 8'h0);
        else n_pass++;
    endtask

    task automatic test_malformed();
        int tx0, wr0;
        send_byte(8'h52);
        tx0 = obs_tx.size() + 1;
        wr0 = obs_wr.size();
        send_str("123456789");
        send_byte(8'h0D);
        send_str("12G45678");
        send_byte(8'h0D);
        drain();
        n_checks++;
        if (obs_wr.size() !== wr0) $display("FAIL mal_writes: got %0d want %0d", obs_wr.size(), wr0);
        else n_pass++;
        n_checks++;
        if (obs_tx.size() !== exp_tx.size())
            $display("FAIL mal_tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        for (int i = tx0 - 1; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i])
                $display("FAIL mal_tx[%0d]: got %h want %h", i, obs_tx[i], exp_tx[i]);
            else n_pass++;
        end
    endtask

    task automatic test_busy_hold();
        int clr0, tx0, t;
        send_str("0000ABCD");
        drain();
        force_busy = 1'b1;
        send_byte(8'h0D);
        @(negedge clk);
        bus.rx_data = 8'h52;
        bus.rx_rdy  = 1'b1;
        clr0 = n_clr;
        tx0  = obs_tx.size();
        repeat (50) @(negedge clk);
        n_checks++;
        if (n_clr !== clr0 || obs_tx.size() !== tx0)
            $display("FAIL busy_hold: clr=%0d tx=%0d want %0d/%0d", n_clr - clr0,
                     obs_tx.size() - tx0, 0, 0);
        else n_pass++;
        force_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.tx_wr_en !== 1'b1) $display("FAIL busy_release: tx_wr_en=%b want 1", bus.tx_wr_en);
        else n_pass++;
        t = 0;
        while (!bus.rx_rdy_clr && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!bus.rx_rdy_clr) $display("FAIL busy_pending_byte: not consumed after %0d cycles", t);
        else n_pass++;
        bus.rx_rdy = 1'b0;
        mdl_byte(8'h52);
        drain();
        n_checks++;
        if (obs_tx.size() !== exp_tx.size() || obs_wr.size() !== exp_wr.size())
            $display("FAIL busy_streams: tx=%0d wr=%0d want %0d/%0d", obs_tx.size(),
                     obs_wr.size(), exp_tx.size(), exp_wr.size());
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        int sz, tx0, wr0;
        send_str("12");
        drain();
        force_busy = 1'b1;
        sz = exp_tx.size();
        send_byte(8'h0D);
        repeat (5) @(negedge clk);
        while (exp_tx.size() > sz) exp_tx.pop_back();
        tx0 = obs_tx.size();
        apply_reset();
        force_busy = 1'b0;
        drain();
        n_checks++;
        if (obs_tx.size() !== tx0 || bus.err !== 1'b0)
            $display("FAIL rst_resp: tx=%0d err=%b want 0/0", obs_tx.size() - tx0, bus.err);
        else n_pass++;
        wr0 = obs_wr.size();
        send_str("1234");
        apply_reset();
        send_str("0000000A");
        send_byte(8'h0D);
        drain();
        n_checks++;
        if (obs_wr.size() !== wr0 + 1 || obs_wr[obs_wr.size()-1] !== {32'd0, 32'h0000000A})
            $display("FAIL rst_midline: writes=%0d last=%h want %0d/%h", obs_wr.size() - wr0,
                     obs_wr.size() ? obs_wr[obs_wr.size()-1] : 64'h0, 1, {32'd0, 32'hA});
        else n_pass++;
    endtask

    task automatic test_random();
        int tx0, wr0, r;
        logic [7:0] b;
        logic [7:0] hexset[22];
        logic [7:0] badset[8];
        string h, bad;
        h   = "0123456789ABCDEFabcdef";
        bad = "Gz /:@`g";
        for (int i = 0; i < 22; i++) hexset[i] = h[i];
        for (int i = 0; i < 8; i++) badset[i] = bad[i];
        tx0 = obs_tx.size();
        wr0 = obs_wr.size();
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 72) b = hexset[$urandom_range(0, 21)];
            else if (r < 84) b = 8'h0D;
            else if (r < 89) b = 8'h0A;
            else if (r < 92) b = 8'h52;
            else b = badset[$urandom_range(0, 7)];
            send_byte(b);
        end
        drain();
        n_checks++;
        if (obs_wr.size() !== exp_wr.size())
            $display("FAIL rnd_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
        else n_pass++;
        for (int i = wr0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== exp_wr[i])
                $display("FAIL rnd_wr[%0d]: got %h want %h", i, obs_wr[i], exp_wr[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_tx.size() !== exp_tx.size())
            $display("FAIL rnd_tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size());
        else n_pass++;
        for (int i = tx0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i])
                $display("FAIL rnd_tx[%0d]: got %h want %h", i, obs_tx[i], exp_tx[i]);
            else n_pass++;
        end
        n_checks++;
        if (bus.full !== m_full || bus.err !== m_err || int'(bus.mem_addr) !== m_addr)
            $display("FAIL rnd_state: full=%b err=%b addr=%0d want %b/%b/%0d", bus.full, bus.err,
                     bus.mem_addr, m_full, m_err, m_addr);
        else n_pass++;
        n_checks++;
        if (viol !== 0) $display("FAIL tx_protocol: violations=%0d want 0", viol);
        else n_pass++;
    endtask

    initial begin
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        mdl_reset();
        test_reset();
        test_deadbeef();
        test_error_rewind();
        test_full();
        test_malformed();
        test_busy_hold();
        test_reset_midline();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
